// File: rtl/vx_fpu_sqrt_rsp_buf.sv
// Response FIFO behind the FPU square-root unit with a sticky fflags accumulator.
// Optional zero-latency bypass when empty: define FSQRT_RSP_BYPASS_EN.
module vx_fpu_sqrt_rsp_buf #(
  parameter int NUM_LANES = 1,
  parameter int TAG_WIDTH = 1,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [NUM_LANES*32-1:0]      result_in,
  input  logic                         has_fflags_in,
  input  logic [4:0]                   fflags_in,
  input  logic [TAG_WIDTH-1:0]         tag_in,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [NUM_LANES*32-1:0]      result_out,
  output logic                         has_fflags,
  output logic [4:0]                   fflags,
  output logic [TAG_WIDTH-1:0]         tag_out,
  output logic [4:0]                   fflags_acc,
  input  logic                         acc_clr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int RES_W = NUM_LANES * 32;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  function automatic logic [4:0] mask_fflags(input logic has, input logic [4:0] flags);
    return has ? flags : 5'b0;
  endfunction

  logic [RES_W-1:0]     res_mem [DEPTH];
  logic                 hf_mem  [DEPTH];
  logic [4:0]           ff_mem  [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             bypass;
  logic             empty;
  logic             push, pop, push_st, pop_st;
  logic [4:0]       acc_nxt;

  assign empty    = (count == '0);
  assign ready_in = (count != FULL_CNT);

`ifdef FSQRT_RSP_BYPASS_EN
  assign bypass = empty && ready_out;
`else
  assign bypass = 1'b0;
`endif

  // While bypassing, the head is the live input and nothing is stored.
  always_comb begin
    if (bypass) begin
      valid_out  = valid_in;
      result_out = result_in;
      has_fflags = has_fflags_in;
      fflags     = mask_fflags(has_fflags_in, fflags_in);
      tag_out    = tag_in;
    end else begin
      valid_out  = !empty;
      result_out = res_mem[rd_ptr];
      has_fflags = hf_mem[rd_ptr];
      fflags     = ff_mem[rd_ptr];
      tag_out    = tag_mem[rd_ptr];
    end
  end

  assign push    = valid_in && ready_in;
  assign pop     = valid_out && ready_out;
  assign push_st = push && !bypass;
  assign pop_st  = pop && !bypass;

  // A clear and a same-cycle pop leave only the popped flags.
  assign acc_nxt = (acc_clr ? 5'b0 : fflags_acc) | (pop ? fflags : 5'b0);

  always_ff @(posedge clk) begin
    if (push_st) begin
      res_mem[wr_ptr] <= result_in;
      hf_mem[wr_ptr]  <= has_fflags_in;
      ff_mem[wr_ptr]  <= mask_fflags(has_fflags_in, fflags_in);
      tag_mem[wr_ptr] <= tag_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fflags_acc <= '0;
    end else begin
      if (push_st) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_st)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_st, pop_st})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      fflags_acc <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_vx_fpu_sqrt_rsp_buf.sv
// Directed bench for vx_fpu_sqrt_rsp_buf (DEPTH=4, TAG_WIDTH=4, one lane).
module tb_vx_fpu_sqrt_rsp_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] result_in;
  logic        has_fflags_in;
  logic [4:0]  fflags_in;
  logic [3:0]  tag_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] result_out;
  logic        has_fflags;
  logic [4:0]  fflags;
  logic [3:0]  tag_out;
  logic [4:0]  fflags_acc;
  logic        acc_clr;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  vx_fpu_sqrt_rsp_buf #(.NUM_LANES(1), .TAG_WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in), .result_in(result_in),
    .has_fflags_in(has_fflags_in), .fflags_in(fflags_in), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .result_out(result_out),
    .has_fflags(has_fflags), .fflags(fflags), .tag_out(tag_out),
    .fflags_acc(fflags_acc), .acc_clr(acc_clr), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] tg,
                       input logic hf, input logic [4:0] ff);
    valid_in      = v;
    result_in     = res;
    tag_in        = tg;
    has_fflags_in = hf;
    fflags_in     = ff;
  endtask

  initial begin
    reset = 1'b0; ready_out = 1'b0; acc_clr = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 5'h0);
    step(); step();
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_ready_in", 32'(ready_in), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_acc", 32'(fflags_acc), 32'd0);
    reset = 1'b1;
    step();

    // single push, then pop
    drive(1'b1, 32'h40000000, 4'h1, 1'b0, 5'h0);
    #2 check("single_no_comb_valid", 32'(valid_out), 32'd0);
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 5'h0);
    #2;
    check("single_valid", 32'(valid_out), 32'd1);
    check("single_result", result_out, 32'h40000000);
    check("single_tag", 32'(tag_out), 32'd1);
    check("single_count", 32'(count), 32'd1);
    ready_out = 1'b1;
    step();
    ready_out = 1'b0;
    #2;
    check("single_pop_count", 32'(count), 32'd0);
    check("single_pop_valid", 32'(valid_out), 32'd0);

    // fill to DEPTH, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 4'(i), 1'b0, 5'h0);
      step();
    end
    drive(1'b1, 32'hDEAD, 4'hF, 1'b0, 5'h0);
    #2;
    check("full_count", 32'(count), 32'd4);
    check("full_ready_in", 32'(ready_in), 32'd0);
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 5'h0);
    check("full_rejected_count", 32'(count), 32'd4);
    ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("drain_tag%0d", i), 32'(tag_out), 32'(i));
      check($sformatf("drain_res%0d", i), result_out, 32'h100 + 32'(i));
      step();
      if (i == 0) begin
        check("drain_ready_in_after_pop", 32'(ready_in), 32'd1);
        check("drain_count_after_pop", 32'(count), 32'd3);
      end
    end
    ready_out = 1'b0;
    #2 check("drain_empty", 32'(valid_out), 32'd0);

    // streaming push&pop at count=1 across pointer wrap
    drive(1'b1, 32'h200, 4'h0, 1'b0, 5'h0);
    step();
    ready_out = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h201 + 32'(i), 4'(i + 1), 1'b0, 5'h0);
      #2;
      check($sformatf("stream_tag%0d", i), 32'(tag_out), 32'(i));
      check($sformatf("stream_count%0d", i), 32'(count), 32'd1);
      step();
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, 5'h0);
    #2;
    check("stream_last_tag", 32'(tag_out), 32'd10);
    check("stream_last_res", result_out, 32'h20A);
    step();
    ready_out = 1'b0;
    check("stream_end_count", 32'(count), 32'd0);

    // fflags accumulation and clear-with-pop
    drive(1'b1, 32'h1, 4'h1, 1'b1, 5'b10000); step();
    drive(1'b1, 32'h2, 4'h2, 1'b1, 5'b00001); step();
    drive(1'b1, 32'h3, 4'h3, 1'b1, 5'b00100); step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 5'h0);
    #2 check("acc_head_fflags", 32'(fflags), 32'b10000);
    ready_out = 1'b1;
    step(); step();
    ready_out = 1'b0;
    check("acc_or", 32'(fflags_acc), 32'b10001);
    ready_out = 1'b1; acc_clr = 1'b1;
    step();
    ready_out = 1'b0; acc_clr = 1'b0;
    check("acc_clr_pop", 32'(fflags_acc), 32'b00100);

    // has_fflags_in=0 masks stored flags
    drive(1'b1, 32'h4, 4'h4, 1'b0, 5'b11111); step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 5'h0);
    #2;
    check("mask_fflags", 32'(fflags), 32'd0);
    check("mask_has_fflags", 32'(has_fflags), 32'd0);
    ready_out = 1'b1; step(); ready_out = 1'b0;
    check("mask_acc_unchanged", 32'(fflags_acc), 32'b00100);

    // async reset with three entries held
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 4'(i), 1'b1, 5'b01000); step();
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, 5'h0);
    check("prereset_count", 32'(count), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("arst_valid_out", 32'(valid_out), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_acc", 32'(fflags_acc), 32'd0);
    check("arst_ready_in", 32'(ready_in), 32'd1);
    step();
    reset = 1'b1;
    step();

    // empty + ready_out push: bypass or one-cycle latency
    ready_out = 1'b1;
    drive(1'b1, 32'h3F800000, 4'h5, 1'b1, 5'b00010);
    #2;
`ifdef FSQRT_RSP_BYPASS_EN
    check("byp_valid", 32'(valid_out), 32'd1);
    check("byp_result", result_out, 32'h3F800000);
    check("byp_tag", 32'(tag_out), 32'd5);
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 5'h0);
    check("byp_count", 32'(count), 32'd0);
    check("byp_acc", 32'(fflags_acc), 32'b00010);
`else
    check("nobyp_valid", 32'(valid_out), 32'd0);
    step();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 5'h0);
    #2;
    check("nobyp_count", 32'(count), 32'd1);
    check("nobyp_tag", 32'(tag_out), 32'd5);
    step();
    check("nobyp_count_after", 32'(count), 32'd0);
    check("nobyp_acc", 32'(fflags_acc), 32'b00010);
`endif
    ready_out = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
